// File: rtl/instr_encoder.sv
// instr_encoder -- program loader for instruction memory.
//
// Packs field-level instruction requests into 32-bit decode-format words and
// writes them to consecutive imem word addresses starting at 0. After the
// beat flagged in_last, PAD_NOPS NOP words are appended so the pipeline
// drains. A one-cycle done pulse then marks the end of the program, and the
// loader rearms at address 0.
//
// Parameters
//   ADDR_W    imem word-address width (capacity 2**ADDR_W words)
//   PAD_NOPS  NOP words appended after the last instruction (0 allowed)
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  request handshake (ready only while loading)
//   in_op/rd/rs/rt  opcode and register fields
//   in_imm          LW/SW offset
//   in_last         final instruction of the program
//   imem_we/addr/wdata  registered imem write port
//   done            one-cycle pulse once program and padding are written
//   err_ovf         sticky: a word was dropped because imem was full
module instr_encoder #(
  parameter int ADDR_W   = 8,
  parameter int PAD_NOPS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err_ovf
);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_PAD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int PAD_W = $clog2(PAD_NOPS + 1) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  function automatic logic [31:0] encode(
    input logic [2:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    logic [31:0] word;
    case (op)
      3'd1:    word = {6'd2, rs, rt, rd, 5'd10, 6'd32};
      3'd2:    word = {6'd2, rs, rt, rd, 5'd10, 6'd34};
      3'd3:    word = {6'd2, rs, rt, rd, 5'd10, 6'd36};
      3'd4:    word = {6'd2, rs, rt, rd, 5'd10, 6'd37};
      3'd5:    word = {6'd2, rs, rt, rd, 5'd10, 6'd50};
      3'd6:    word = {6'd3, rs, rt, imm};
      3'd7:    word = {6'd4, rs, rt, imm};
      default: word = 32'h0;
    endcase
    return word;
  endfunction

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              full;
  logic [PAD_W-1:0]  pad_left;

  logic              accept_p0;
  logic              wr_req_p0;
  logic [31:0]       word_p0;

  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;
  logic              ovf;

  assign in_ready = (state == S_LOAD);
  assign done     = (state == S_DONE);

  // Stage p0: handshake and encoding; pad cycles request a NOP write.
  assign accept_p0 = in_valid & in_ready;
  assign wr_req_p0 = accept_p0 | (state == S_PAD);
  assign word_p0   = (state == S_PAD) ? 32'h0
                                      : encode(in_op, in_rd, in_rs, in_rt, in_imm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_LOAD;
      wr_ptr   <= '0;
      full     <= 1'b0;
      pad_left <= '0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= 32'h0;
      ovf      <= 1'b0;
    end else begin
      // Stage p1: registered imem write. Once the top address has been
      // written the pointer parks there and further words are dropped.
      we_p1 <= 1'b0;
      if (wr_req_p0) begin
        if (full) begin
          ovf <= 1'b1;
        end else begin
          we_p1    <= 1'b1;
          addr_p1  <= wr_ptr;
          wdata_p1 <= word_p0;
          if (wr_ptr == LAST_ADDR) full <= 1'b1;
          else                     wr_ptr <= wr_ptr + ADDR_W'(1);
        end
      end

      case (state)
        S_LOAD: begin
          if (accept_p0 && in_last) begin
            if (PAD_NOPS == 0) begin
              state <= S_DONE;
            end else begin
              state    <= S_PAD;
              pad_left <= PAD_W'(PAD_NOPS);
            end
          end
        end
        S_PAD: begin
          pad_left <= pad_left - PAD_W'(1);
          if (pad_left == PAD_W'(1)) state <= S_DONE;
        end
        S_DONE: begin
          state  <= S_LOAD;
          wr_ptr <= '0;
          full   <= 1'b0;
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  assign imem_we    = we_p1;
  assign imem_addr  = addr_p1;
  assign imem_wdata = wdata_p1;
  assign err_ovf    = ovf;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder. Three instances share one input stream:
//   a: ADDR_W=8, PAD_NOPS=3 (main checks)
//   b: ADDR_W=2, PAD_NOPS=3 (overflow behaviour)
//   c: ADDR_W=8, PAD_NOPS=0 (no padding)
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rs, in_rt;
  logic [15:0] in_imm;
  logic        in_last;

  logic        ready_a, we_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic        ready_b, we_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic        ready_c, we_c, done_c, err_c;
  logic [7:0]  addr_c;
  logic [31:0] wdata_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8), .PAD_NOPS(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_a), .imem_addr(addr_a),
    .imem_wdata(wdata_a), .done(done_a), .err_ovf(err_a));

  instr_encoder #(.ADDR_W(2), .PAD_NOPS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_b), .imem_addr(addr_b),
    .imem_wdata(wdata_b), .done(done_b), .err_ovf(err_b));

  instr_encoder #(.ADDR_W(8), .PAD_NOPS(0)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_c),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
    .in_imm(in_imm), .in_last(in_last), .imem_we(we_c), .imem_addr(addr_c),
    .imem_wdata(wdata_c), .done(done_c), .err_ovf(err_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [15:0] imm, input logic last);
    in_valid = 1'b1;
    in_op    = op;
    in_rd    = rd;
    in_rs    = rs;
    in_rt    = rt;
    in_imm   = imm;
    in_last  = last;
  endtask

  task automatic idle;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b0;
    idle();
    in_op = 3'd0; in_rd = 5'd0; in_rs = 5'd0; in_rt = 5'd0; in_imm = 16'h0;
    tick();
    do_reset();

    // Reset state
    chk("rst_we",    we_a,    0);
    chk("rst_addr",  addr_a,  0);
    chk("rst_wdata", wdata_a, 0);
    chk("rst_done",  done_a,  0);
    chk("rst_err",   err_a,   0);
    chk("rst_ready", ready_a, 1);

    // 1: single ADD
    drive(3'd1, 5'd3, 5'd1, 5'd2, 16'hFFFF, 1'b0);
    tick();
    idle();
    chk("add_we",    we_a,    1);
    chk("add_addr",  addr_a,  0);
    chk("add_wdata", wdata_a, 32'h08221AA0);
    tick();
    chk("add_idle_we", we_a, 0);

    // 2: MUL then LW back-to-back, then SUB/AND/OR with imm ignored
    do_reset();
    drive(3'd5, 5'd7, 5'd1, 5'd2, 16'h0, 1'b0);
    tick();
    chk("mul_addr",  addr_a,  0);
    chk("mul_wdata", wdata_a, 32'h08223AB2);
    drive(3'd6, 5'd0, 5'd4, 5'd5, 16'h0010, 1'b0);
    tick();
    chk("lw_we",    we_a,    1);
    chk("lw_addr",  addr_a,  1);
    chk("lw_wdata", wdata_a, 32'h0C850010);
    drive(3'd2, 5'd5, 5'd6, 5'd7, 16'hFFFF, 1'b0);
    tick();
    chk("sub_wdata", wdata_a, 32'h08C72AA2);
    drive(3'd3, 5'd5, 5'd6, 5'd7, 16'hFFFF, 1'b0);
    tick();
    chk("and_wdata", wdata_a, 32'h08C72AA4);
    drive(3'd4, 5'd5, 5'd6, 5'd7, 16'hFFFF, 1'b0);
    tick();
    idle();
    chk("or_wdata", wdata_a, 32'h08C72AA5);
    chk("or_addr",  addr_a,  4);

    // 3: SW as last instruction, three pad NOPs, done pulse, restart at 0
    do_reset();
    drive(3'd7, 5'd0, 5'd4, 5'd6, 16'h0008, 1'b1);
    tick();
    idle();
    chk("sw_addr",   addr_a,  0);
    chk("sw_wdata",  wdata_a, 32'h10860008);
    chk("sw_ready",  ready_a, 0);
    chk("sw_done",   done_a,  0);
    chk("c_we",      we_c,    1);
    chk("c_done",    done_c,  1);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("pad_we",    we_a,    1);
      chk("pad_addr",  addr_a,  k);
      chk("pad_wdata", wdata_a, 0);
      chk("pad_ready", ready_a, 0);
      chk("pad_done",  done_a,  (k == 3) ? 1 : 0);
      if (k == 1) begin
        chk("c_done_off", done_c,  0);
        chk("c_ready",    ready_c, 1);
        chk("c_pad_we",   we_c,    0);
      end
    end
    tick();
    chk("post_done",  done_a,  0);
    chk("post_ready", ready_a, 1);
    chk("post_we",    we_a,    0);
    drive(3'd1, 5'd3, 5'd1, 5'd2, 16'h0, 1'b0);
    tick();
    idle();
    chk("restart_we",   we_a,   1);
    chk("restart_addr", addr_a, 0);

    // 4: overflow on the 4-word instance
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(3'd0, 5'd31, 5'd31, 5'd31, 16'hFFFF, (k == 5) ? 1'b1 : 1'b0);
      tick();
      if (k < 4) begin
        chk("ovf_we",   we_b,   1);
        chk("ovf_addr", addr_b, k);
        chk("ovf_err",  err_b,  0);
      end else begin
        chk("drop_we",  we_b,   0);
        chk("drop_err", err_b,  1);
      end
      if (k == 0) chk("nop_wdata", wdata_a, 0);
    end
    idle();
    seen = 1'b0;
    for (int n = 0; n < 8 && !seen; n++) begin
      if (done_b) seen = 1'b1;
      else begin
        chk("ovf_pad_we", we_b, 0);
        tick();
      end
    end
    chk("ovf_done_seen", seen,  1);
    chk("ovf_err_kept",  err_b, 1);
    chk("a_no_err",      err_a, 0);
    tick();
    chk("ovf_done_off",  done_b, 0);
    chk("ovf_err_stick", err_b,  1);

    // 5: reset during PAD after one pad word
    drive(3'd7, 5'd0, 5'd4, 5'd6, 16'h0008, 1'b1);
    tick();
    idle();
    tick();
    chk("pad1_we",   we_a,   1);
    chk("pad1_addr", addr_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_we",    we_a,    0);
    chk("mid_ready", ready_a, 1);
    chk("mid_addr",  addr_a,  0);
    chk("mid_wdata", wdata_a, 0);
    chk("mid_done",  done_a,  0);
    chk("mid_err_b", err_b,   0);
    drive(3'd1, 5'd3, 5'd1, 5'd2, 16'h0, 1'b0);
    tick();
    idle();
    chk("after_rst_addr",  addr_a,  0);
    chk("after_rst_wdata", wdata_a, 32'h08221AA0);

    // 6: in_valid 1,0,1
    do_reset();
    drive(3'd1, 5'd1, 5'd1, 5'd2, 16'h0, 1'b0);
    tick();
    idle();
    chk("gap1_we",   we_a,   1);
    chk("gap1_addr", addr_a, 0);
    tick();
    chk("gap_we", we_a, 0);
    drive(3'd1, 5'd2, 5'd1, 5'd2, 16'h0, 1'b0);
    tick();
    idle();
    chk("gap2_we",    we_a,    1);
    chk("gap2_addr",  addr_a,  1);
    chk("gap2_wdata", wdata_a, 32'h082212A0);
    tick();
    chk("gap_end_we", we_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
